kmeans_centroid_accum: RTL and testbench

KMEANS_CENTROID_ACCUM -- requirements
Module: kmeans_centroid_accum

---
 rtl/kmeans_pkg.sv | 18 +
 rtl/kmeans_centroid_accum_if.sv | 16 +
 rtl/kmeans_centroid_accum_div.sv | 62 ++++++
 rtl/kmeans_centroid_accum.sv | 187 ++++++++++++++++++
 tb/tb_kmeans_centroid_accum.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/kmeans_pkg.sv
// Shared k-means definitions: controller state encoding and default widths,
// also used by the cluster-assignment logic.
package kmeans_pkg;

  localparam int K_DEF         = 4;
  localparam int X_WIDTH_DEF   = 11;
  localparam int Y_WIDTH_DEF   = 10;
  localparam int SUM_WIDTH_DEF = 32;
  localparam int MIN_AREA_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } kmeans_state_e;

endpackage

// File: rtl/kmeans_centroid_accum_if.sv
// Request/response bus between the centroid controller and its shared divider.
// Handshake: master raises start for exactly one cycle with dividend/divisor
// valid in that cycle; slave answers later with a one-cycle done pulse, and
// quotient is valid while done is high. Only one divide is outstanding at a time.
interface kmeans_div_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         done;
  logic [W-1:0] quotient;

  modport master (output start, dividend, divisor, input done, quotient);
  modport slave  (input start, dividend, divisor, output done, quotient);
endinterface

// File: rtl/kmeans_centroid_accum_div.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// done pulses W+1 cycles after start; a zero divisor is never requested.
module kmeans_centroid_accum_div #(
  parameter int W = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  kmeans_div_if.slave  div
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;
  logic [W-1:0]     dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;
  logic [W:0]       trial;
  logic [W:0]       diff;
  logic             ge;

  // The partial remainder stays below 2*divisor, so a borrow-free subtract
  // always leaves a zero top bit.
  always_comb begin
    trial = {rem_q, quo_q[W-1]};
    diff  = trial - {1'b0, dvs_q};
    ge    = ~diff[W];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (div.start) begin
        rem_q <= '0;
        quo_q <= div.dividend;
        dvs_q <= div.divisor;
        cnt_q <= CNT_W'(W);
        run_q <= 1'b1;
      end else if (run_q) begin
        rem_q <= ge ? diff[W-1:0] : trial[W-1:0];
        quo_q <= {quo_q[W-2:0], ge};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign div.done     = done_q;
  assign div.quotient = quo_q;

endmodule

// File: rtl/kmeans_centroid_accum.sv
// Per-cluster pixel accumulator with double-buffered banks; a frame snapshot is
// turned into centroids by one time-shared divider while the next frame accumulates.
module kmeans_centroid_accum
  import kmeans_pkg::*;
#(
  parameter int K         = K_DEF,
  parameter int X_WIDTH   = X_WIDTH_DEF,
  parameter int Y_WIDTH   = Y_WIDTH_DEF,
  parameter int SUM_WIDTH = SUM_WIDTH_DEF,
  parameter int MIN_AREA  = MIN_AREA_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [X_WIDTH-1:0]   x_in,
  input  logic [Y_WIDTH-1:0]   y_in,
  input  logic [$clog2(K)-1:0] cluster_id_in,
  input  logic                 valid_in,
  input  logic                 tabulate_in,
  output logic [X_WIDTH-1:0]   x_out [K],
  output logic [Y_WIDTH-1:0]   y_out [K],
  output logic [SUM_WIDTH-1:0] area_out [K],
  output logic                 valid_out [K],
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 overrun_out,
  output kmeans_state_e        state_out
);

  localparam int ID_W  = $clog2(K);
  localparam int IDX_W = $clog2(2 * K);
  localparam int CL_W  = IDX_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * K - 1);

  kmeans_state_e        state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CL_W-1:0]      cur_cl;
  logic                 tab_accept;
  logic                 q_we;
  logic                 q_zero;
  logic                 done_q, overrun_q;

  logic                 hit    [K];
  logic [SUM_WIDTH-1:0] act_x_q [K], act_x_d [K], snap_x_q [K], snap_x_d [K];
  logic [SUM_WIDTH-1:0] act_y_q [K], act_y_d [K], snap_y_q [K], snap_y_d [K];
  logic [SUM_WIDTH-1:0] act_n_q [K], act_n_d [K], snap_n_q [K], snap_n_d [K];
  logic [SUM_WIDTH-1:0] sum_x [K], sum_y [K], sum_n [K];
  logic [X_WIDTH-1:0]   qx_q [K], res_x_q [K];
  logic [Y_WIDTH-1:0]   qy_q [K], res_y_q [K];
  logic [SUM_WIDTH-1:0] res_n_q [K];
  logic                 res_v_q [K];

  kmeans_div_if #(.W(SUM_WIDTH)) div_bus ();

  kmeans_centroid_accum_div #(.W(SUM_WIDTH)) u_div (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .div    (div_bus)
  );

  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] a,
                                                   input logic [SUM_WIDTH-1:0] b);
    logic [SUM_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : s[SUM_WIDTH-1:0];
  endfunction

  assign tab_accept = tabulate_in && (state_q == ST_IDLE);
  assign cur_cl     = idx_q[IDX_W-1:1];

  // A pixel landing in the tabulate cycle goes into the snapshot, and the
  // active bank restarts from zero on the same edge.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      hit[i]      = valid_in && (cluster_id_in == ID_W'(i));
      sum_x[i]    = sat_add(act_x_q[i], hit[i] ? SUM_WIDTH'(x_in) : '0);
      sum_y[i]    = sat_add(act_y_q[i], hit[i] ? SUM_WIDTH'(y_in) : '0);
      sum_n[i]    = sat_add(act_n_q[i], SUM_WIDTH'(hit[i]));
      act_x_d[i]  = tab_accept ? '0 : sum_x[i];
      act_y_d[i]  = tab_accept ? '0 : sum_y[i];
      act_n_d[i]  = tab_accept ? '0 : sum_n[i];
      snap_x_d[i] = tab_accept ? sum_x[i] : snap_x_q[i];
      snap_y_d[i] = tab_accept ? sum_y[i] : snap_y_q[i];
      snap_n_d[i] = tab_accept ? sum_n[i] : snap_n_q[i];
    end
  end

  // Divide index walks cluster-major: even index is x, odd index is y.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    q_we             = 1'b0;
    q_zero           = 1'b0;
    div_bus.start    = 1'b0;
    div_bus.dividend = idx_q[0] ? snap_y_q[cur_cl] : snap_x_q[cur_cl];
    div_bus.divisor  = snap_n_q[cur_cl];
    case (state_q)
      ST_IDLE: begin
        if (tab_accept) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (snap_n_q[cur_cl] == '0) begin
          q_we   = 1'b1;
          q_zero = 1'b1;
          if (idx_q == LAST_IDX) state_d = ST_COMMIT;
          else idx_d = idx_q + 1'b1;
        end else begin
          div_bus.start = 1'b1;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (div_bus.done) begin
          q_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < K; i++) begin
        act_x_q[i]  <= '0;
        act_y_q[i]  <= '0;
        act_n_q[i]  <= '0;
        snap_x_q[i] <= '0;
        snap_y_q[i] <= '0;
        snap_n_q[i] <= '0;
        qx_q[i]     <= '0;
        qy_q[i]     <= '0;
        res_x_q[i]  <= '0;
        res_y_q[i]  <= '0;
        res_n_q[i]  <= '0;
        res_v_q[i]  <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= (state_q == ST_COMMIT);
      overrun_q <= tabulate_in && (state_q != ST_IDLE);
      for (int i = 0; i < K; i++) begin
        act_x_q[i]  <= act_x_d[i];
        act_y_q[i]  <= act_y_d[i];
        act_n_q[i]  <= act_n_d[i];
        snap_x_q[i] <= snap_x_d[i];
        snap_y_q[i] <= snap_y_d[i];
        snap_n_q[i] <= snap_n_d[i];
      end
      if (q_we) begin
        if (idx_q[0]) qy_q[cur_cl] <= q_zero ? '0 : Y_WIDTH'(div_bus.quotient);
        else          qx_q[cur_cl] <= q_zero ? '0 : X_WIDTH'(div_bus.quotient);
      end
      if (state_q == ST_COMMIT) begin
        for (int i = 0; i < K; i++) begin
          res_x_q[i] <= qx_q[i];
          res_y_q[i] <= qy_q[i];
          res_n_q[i] <= snap_n_q[i];
          res_v_q[i] <= (snap_n_q[i] >= SUM_WIDTH'(MIN_AREA));
        end
      end
    end
  end

  assign x_out       = res_x_q;
  assign y_out       = res_y_q;
  assign area_out    = res_n_q;
  assign valid_out   = res_v_q;
  assign busy_out    = (state_q != ST_IDLE);
  assign done_out    = done_q;
  assign overrun_out = overrun_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_kmeans_centroid_accum.sv
// Randomized bench for kmeans_centroid_accum against a frame-level model of
// per-cluster sums, counts and truncated mean coordinates.
module tb_kmeans_centroid_accum;
  import kmeans_pkg::*;

  localparam int K        = 4;
  localparam int XW       = 11;
  localparam int YW       = 10;
  localparam int SW       = 32;
  localparam int MIN_AREA = 16;
  localparam int LAT_MAX  = 2 * K * ((SW + 1) + 2) + 2;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [XW-1:0] x_in;
  logic [YW-1:0] y_in;
  logic [1:0]    cluster_id_in;
  logic          valid_in;
  logic          tabulate_in;
  logic [XW-1:0] x_out [K];
  logic [YW-1:0] y_out [K];
  logic [SW-1:0] area_out [K];
  logic          valid_out [K];
  logic          busy_out;
  logic          done_out;
  logic          overrun_out;
  kmeans_state_e state_out;

  kmeans_centroid_accum #(
    .K(K), .X_WIDTH(XW), .Y_WIDTH(YW), .SUM_WIDTH(SW), .MIN_AREA(MIN_AREA)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .x_in          (x_in),
    .y_in          (y_in),
    .cluster_id_in (cluster_id_in),
    .valid_in      (valid_in),
    .tabulate_in   (tabulate_in),
    .x_out         (x_out),
    .y_out         (y_out),
    .area_out      (area_out),
    .valid_out     (valid_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .overrun_out   (overrun_out),
    .state_out     (state_out)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: active-frame sums, a queue of expected result sets, last committed set
  longint        m_x [K];
  longint        m_y [K];
  longint        m_n [K];
  bit            m_busy;
  int            wait_cnt;
  logic [SW-1:0] exp_q[$];
  longint        held_x [K];
  longint        held_y [K];
  longint        held_n [K];
  longint        held_v [K];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint sat_add(input longint a, input longint b);
    longint lim;
    lim = (longint'(1) << SW) - 1;
    return (a + b > lim) ? lim : a + b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < K; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_n[i] = 0;
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < K; i++) begin
      longint mx, my;
      mx = (m_n[i] == 0) ? 0 : m_x[i] / m_n[i];
      my = (m_n[i] == 0) ? 0 : m_y[i] / m_n[i];
      exp_q.push_back(SW'(mx % (longint'(1) << XW)));
      exp_q.push_back(SW'(my % (longint'(1) << YW)));
      exp_q.push_back(SW'(m_n[i]));
      exp_q.push_back(SW'(m_n[i] >= MIN_AREA));
    end
  endtask

  task automatic compare_frame();
    for (int i = 0; i < K; i++) begin
      held_x[i] = exp_q.pop_front();
      held_y[i] = exp_q.pop_front();
      held_n[i] = exp_q.pop_front();
      held_v[i] = exp_q.pop_front();
      check_val($sformatf("frame_x[%0d]", i), x_out[i], held_x[i]);
      check_val($sformatf("frame_y[%0d]", i), y_out[i], held_y[i]);
      check_val($sformatf("frame_area[%0d]", i), area_out[i], held_n[i]);
      check_val($sformatf("frame_valid[%0d]", i), valid_out[i], held_v[i]);
    end
  endtask

  task automatic check_held(input string tag);
    for (int i = 0; i < K; i++) begin
      check_val($sformatf("%s_x[%0d]", tag, i), x_out[i], held_x[i]);
      check_val($sformatf("%s_y[%0d]", tag, i), y_out[i], held_y[i]);
      check_val($sformatf("%s_area[%0d]", tag, i), area_out[i], held_n[i]);
      check_val($sformatf("%s_valid[%0d]", tag, i), valid_out[i], held_v[i]);
    end
  endtask

  // Driver: one clock of stimulus, model update on the same edge, checks at edge+1
  task automatic cycle(input bit v, input int x, input int y, input int id, input bit tab);
    bit exp_ovr;
    valid_in      = v;
    x_in          = XW'(x);
    y_in          = YW'(y);
    cluster_id_in = 2'(id);
    tabulate_in   = tab;
    @(posedge clk_in);
    if (v && id < K) begin
      m_x[id] = sat_add(m_x[id], x);
      m_y[id] = sat_add(m_y[id], y);
      m_n[id] = sat_add(m_n[id], 1);
    end
    exp_ovr = tab && m_busy;
    if (tab && !m_busy) begin
      push_frame();
      model_clear();
      m_busy   = 1'b1;
      wait_cnt = 0;
    end else if (m_busy) begin
      wait_cnt++;
    end
    #1;
    valid_in    = 1'b0;
    tabulate_in = 1'b0;
    if (tab || overrun_out) check_val("overrun", overrun_out, exp_ovr);
    if (done_out) begin
      if (m_busy) begin
        check_val("latency_ok", wait_cnt <= LAT_MAX, 1);
        compare_frame();
        m_busy = 1'b0;
      end else begin
        check_val("spurious_done", done_out, 0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic wait_done();
    for (int c = 0; c < LAT_MAX + 20 && m_busy; c++) cycle(0, 0, 0, 0, 0);
    if (m_busy) begin
      check_val("done_timeout", m_busy, 0);
      m_busy = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_in      = 1'b1;
    valid_in    = 1'b0;
    tabulate_in = 1'b0;
    @(posedge clk_in);
    model_clear();
    m_busy = 1'b0;
    exp_q.delete();
    for (int i = 0; i < K; i++) begin
      held_x[i] = 0; held_y[i] = 0; held_n[i] = 0; held_v[i] = 0;
    end
    #1;
    rst_in = 1'b0;
    check_held("rst");
    check_val("rst_busy", busy_out, 0);
    check_val("rst_done", done_out, 0);
    check_val("rst_overrun", overrun_out, 0);
    check_val("rst_state", state_out, ST_IDLE);
  endtask

  initial begin
    bit v, t;
    rst_in        = 1'b1;
    x_in          = '0;
    y_in          = '0;
    cluster_id_in = '0;
    valid_in      = 1'b0;
    tabulate_in   = 1'b0;
    @(posedge clk_in);
    #1;
    do_reset();

    // Single cluster alternating between two points
    for (int i = 0; i < 20; i++)
      cycle(1, (i % 2) ? 110 : 100, (i % 2) ? 60 : 50, 1, 0);
    cycle(0, 0, 0, 0, 1);
    check_val("busy_after_tab", busy_out, 1);
    wait_done();
    check_val("c1_x", x_out[1], 105);
    check_val("c1_y", y_out[1], 55);
    check_val("c1_area", area_out[1], 20);
    check_val("c1_valid", valid_out[1], 1);
    check_val("c0_area", area_out[0], 0);
    check_val("c2_valid", valid_out[2], 0);
    idle(5);
    check_held("hold1");

    // Area threshold, pixels during division, and a dropped tabulate
    for (int i = 0; i < 15; i++) cycle(1, $urandom_range(0, 2047), $urandom_range(0, 1023), 2, 0);
    for (int i = 0; i < 16; i++) cycle(1, $urandom_range(0, 2047), $urandom_range(0, 1023), 3, 0);
    cycle(0, 0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 4; i++) cycle(1, $urandom_range(0, 2047), $urandom_range(0, 1023), 0, 0);
    check_val("busy_before_overrun", busy_out, 1);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, $urandom_range(0, 2047), $urandom_range(0, 1023), 0, 0);
    wait_done();
    check_val("thr_valid2", valid_out[2], 0);
    check_val("thr_valid3", valid_out[3], 1);
    check_val("thr_area2", area_out[2], 15);
    idle(2);
    cycle(0, 0, 0, 0, 1);
    wait_done();
    check_val("b2b_area0", area_out[0], 8);

    // Pixel arriving in the tabulate cycle
    for (int i = 0; i < 6; i++) cycle(1, $urandom_range(0, 2047), $urandom_range(0, 1023), $urandom_range(1, 3), 0);
    cycle(1, 7, 3, 0, 1);
    wait_done();
    check_val("sim_area0", area_out[0], 1);
    check_val("sim_x0", x_out[0], 7);
    check_val("sim_y0", y_out[0], 3);

    // Random frames with tabulates at arbitrary times
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 60; c++) begin
        v = ($urandom_range(0, 3) != 0);
        t = ($urandom_range(0, 49) == 0);
        cycle(v, $urandom_range(0, 2047), $urandom_range(0, 1023), $urandom_range(0, K - 1), t);
      end
      wait_done();
      cycle(0, 0, 0, 0, 1);
      wait_done();
      idle(3);
      check_held("hold_rand");
    end

    // Reset in the middle of a division
    for (int i = 0; i < 10; i++) cycle(1, $urandom_range(0, 2047), $urandom_range(0, 1023), $urandom_range(0, K - 1), 0);
    cycle(0, 0, 0, 0, 1);
    idle(20);
    check_val("busy_before_rst", busy_out, 1);
    do_reset();
    idle(LAT_MAX + 20);
    check_held("post_rst");
    check_val("post_rst_state", state_out, ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
